// File: rtl/reg_file_param.sv
// Parametrised 2R1W register file with registered reads, optional bypass
// and zero register; a clear sequencer zeroes storage one entry per cycle.
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid,
  output logic              busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0]   NR   = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS-1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_ok;
  logic [DATA_W-1:0] rv1, rv2;

  // Full-width compare so out-of-range addresses never alias.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NR;
  endfunction

  function automatic logic [DATA_W-1:0] rd_val(
    input logic [ADDR_W-1:0] a
  );
    if (!in_range(a))
      return '0;
    else if (ZERO_REG && a == '0)
      return '0;
    else if (BYPASS && wr_ok && waddr == a)
      return wdata;
    else
      return mem[a];
  endfunction

  assign busy  = (state_q == CLEAR);
  assign wr_ok = (state_q == IDLE) && we && in_range(waddr)
               && !(ZERO_REG && waddr == '0);

  always_comb begin
    rv1 = rd_val(raddr1);
    rv2 = rd_val(raddr2);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[ptr_q] <= '0;
    else if (wr_ok)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata1 <= '0;
      rdata2 <= '0;
      rvalid <= 1'b0;
    end else if (state_q == IDLE && re) begin
      rdata1 <= rv1;
      rdata2 <= rv2;
      rvalid <= 1'b1;
    end else begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised register file for the datapath: configurable data width and depth, two read ports, one write port.
- Reads are registered (1-cycle latency) with optional write-to-read bypass.
- Register 0 can optionally be hardwired to zero.
- Storage has no reset. A clear sequencer zeroes it one entry per cycle after reset or on request, so the array maps to plain RAM.

Parameters:
- DATA_W, 8, data width of each register.
- ADDR_W, 5, address width of all address ports.
- NUM_REGS, 32, number of implemented registers; must be <= 2**ADDR_W and >= 2.
- ZERO_REG, 1, 1 = address 0 always reads 0 and writes to it are dropped.
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read data.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  1-cycle pulse; starts a full clear sequence.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re  in  1  read enable; applies to both read ports.
- raddr1  in  ADDR_W  read address, port 1.
- raddr2  in  ADDR_W  read address, port 2.
- rdata1  out  DATA_W  registered read data, port 1.
- rdata2  out  DATA_W  registered read data, port 2.
- rvalid  out  1  rdata1/rdata2 updated by a read issued in the previous cycle.
- busy  out  1  clear sequence in progress; write and read requests are ignored while high.

Behaviour:
- Reset (asynchronous, rst=1):
  - rdata1=0, rdata2=0, rvalid=0.
  - FSM=CLEAR, clear pointer ptr=0, busy=1.
  - Array contents are not reset.
- FSM states: IDLE, CLEAR.
- CLEAR:
  - Each edge writes 0 to entry ptr, then increments ptr.
  - After the edge that writes entry NUM_REGS-1, the FSM goes to IDLE and busy=0.
  - busy is therefore high for exactly NUM_REGS edges after rst falls.
  - clear, we and re are ignored; rvalid=0; rdata1/rdata2 hold their values.
- IDLE:
  - clear=1 moves the FSM to CLEAR with ptr=0 and busy=1 on the next edge.
  - Any we or re in that same cycle is still serviced.
- Write (IDLE, we=1): mem[waddr] <= wdata.
  - Dropped if waddr >= NUM_REGS.
  - Dropped if ZERO_REG=1 and waddr=0.
- Read (IDLE, re=1): on the edge, rdataN <= value at raddrN and rvalid <= 1.
- Read (IDLE, re=0): rvalid <= 0; rdata1/rdata2 hold.
- Read value rules, in priority order:
  - raddrN >= NUM_REGS -> 0.
  - ZERO_REG=1 and raddrN=0 -> 0.
  - BYPASS=1, we=1, waddr=raddrN, and the write is accepted -> wdata.
  - Otherwise -> the stored value before this edge. With BYPASS=0, a same-cycle write therefore returns the old value.
- Both ports may read the same address; both return identical data.
- Width rule: addresses are compared at full ADDR_W width, with no truncation. Out-of-range addresses never alias.
- Reset mid-clear: the sequence restarts from ptr=0.
- clear pulse while already in CLEAR: ignored, with no restart and no extension.

Test Plan:
- Release rst -> busy=1 for exactly 32 cycles, rvalid=0 throughout. Then read addresses 0..31 -> every rdata1/rdata2=0x00, with rvalid=1 one cycle after each re.
- Write 0xA5 to addr 7, 0x3C to addr 9. Next cycle re with raddr1=7, raddr2=9 -> rdata1=0xA5, rdata2=0x3C, rvalid=1. Following cycle re=0 -> rvalid=0 and data held.
- Same cycle: we=1, waddr=4, wdata=0x5A, re=1, raddr1=4. Old value 0x11 -> rdata1=0x5A with BYPASS=1; rdata1=0x11 with BYPASS=0.
- ZERO_REG=1: write 0xFF to addr 0, then read addr 0 on both ports -> 0x00. Bypass read of addr 0 in the same cycle as that write -> 0x00.
- ADDR_W=5, NUM_REGS=20: write 0x77 to addr 25 -> dropped; read addr 25 -> 0x00. Addr 5 keeps its prior value (no aliasing).
- Fill registers with nonzero data, pulse clear, and assert we to addr 3 during the busy window -> busy=1 for 32 cycles and the write is ignored. Afterwards every register reads 0x00. Asserting rst at clear cycle 10 -> busy=1 for 32 further cycles after rst falls.
